// File: rtl/exec_unit.sv
// ---------------------------------------------------------------------------
// exec_unit
//  Execute/write-back stage of the 4-bit processor. It accepts one decoded
//  instruction per handshake and runs it through a fixed four-state sequence:
//  IDLE -> READ -> EXEC -> WB -> IDLE.
//
//  Each instruction reads the selected register and adds or subtracts a
//  zero-extended immediate. The result is written back to the same register.
//  The LED bus shows {flag, result} of the last committed instruction. The flag
//  is the carry for an add and the borrow for a subtract.
//
// Ports
//  clk          in   system clock; all state changes on its rising edge
//  rst          in   asynchronous, active-low reset
//  instr_valid  in   upstream presents a decoded instruction
//  instr_ready  out  high only in IDLE; a handshake is valid & ready at an edge
//  reg_sel      in   source/destination register (0 = R0, 1 = R1)
//  oper         in   0 = add, 1 = subtract
//  number       in   immediate operand, zero-extended to DATA_W
//  busy         out  an instruction is in flight (READ/EXEC/WB)
//  done         out  one-cycle pulse on the cycle after write-back commits
//  led          out  {flag, result} of the last committed instruction
//  r0, r1       out  current register contents
// ---------------------------------------------------------------------------
module exec_unit #(
  parameter int DATA_W = 4,
  parameter int IMM_W  = 2,
  parameter int LED_W  = DATA_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              reg_sel,
  input  logic              oper,
  input  logic [IMM_W-1:0]  number,
  output logic              busy,
  output logic              done,
  output logic [LED_W-1:0]  led,
  output logic [DATA_W-1:0] r0,
  output logic [DATA_W-1:0] r1
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                sel_q, sel_d;
  logic                oper_q, oper_d;
  logic [IMM_W-1:0]    num_q, num_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W:0]     res_q, res_d;   // {flag, result}
  logic [LED_W-1:0]    led_q, led_d;
  logic                done_q, done_d;
  logic                wr_en;
  logic [1:0]          wr_hit;
  logic [DATA_W-1:0]   reg_q [2];
  logic [DATA_W:0]     a_ext;
  logic [DATA_W:0]     imm_ext;

  // The operands are widened by one bit. Bit DATA_W of the sum is the carry.
  // Bit DATA_W of the difference is the borrow.
  assign a_ext   = {1'b0, opa_q};
  assign imm_ext = {{(DATA_W + 1 - IMM_W){1'b0}}, num_q};

  // Next-state and outputs
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    oper_d      = oper_q;
    num_d       = num_q;
    opa_d       = opa_q;
    res_d       = res_q;
    led_d       = led_q;
    done_d      = 1'b0;
    wr_en       = 1'b0;
    instr_ready = 1'b0;
    busy        = 1'b0;

    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          // Instruction fields are captured only here. Later changes to the
          // inputs cannot reach the instruction that is in flight.
          sel_d   = reg_sel;
          oper_d  = oper;
          num_d   = number;
          state_d = S_READ;
        end
      end
      S_READ: begin
        busy    = 1'b1;
        opa_d   = sel_q ? reg_q[1] : reg_q[0];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        busy    = 1'b1;
        res_d   = oper_q ? (a_ext - imm_ext) : (a_ext + imm_ext);
        state_d = S_WB;
      end
      S_WB: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        led_d   = res_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      oper_q  <= 1'b0;
      num_q   <= '0;
      opa_q   <= '0;
      res_q   <= '0;
      led_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      oper_q  <= oper_d;
      num_q   <= num_d;
      opa_q   <= opa_d;
      res_q   <= res_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  // Write-enable per register. Only the latched selection can be written.
  // The other register is never touched.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_wr_hit
      assign wr_hit[gi] = wr_en & (sel_q == 1'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_q[0] <= '0;
      reg_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_hit[i]) reg_q[i] <= res_q[DATA_W-1:0];
      end
    end
  end

  assign done = done_q;
  assign led  = led_q;
  assign r0   = reg_q[0];
  assign r1   = reg_q[1];

endmodule

// File: tb/tb_exec_unit.sv
module tb_exec_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic       reg_sel = 1'b0;
  logic       oper = 1'b0;
  logic [1:0] number = 2'd0;
  logic       busy;
  logic       done;
  logic [4:0] led;
  logic [3:0] r0;
  logic [3:0] r1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  exec_unit dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .reg_sel    (reg_sel),
    .oper       (oper),
    .number     (number),
    .busy       (busy),
    .done       (done),
    .led        (led),
    .r0         (r0),
    .r1         (r1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic       op;
    logic [1:0] num;
    logic [3:0] e_r0;
    logic [3:0] e_r1;
    logic [4:0] e_led;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    instr_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Issue one instruction and check the handshake and timing profile.
  // The inputs are scrambled right after the handshake.
  task automatic issue(input logic s, input logic o, input logic [1:0] n);
    int w;
    w = 0;
    @(negedge clk);
    while (!instr_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!instr_ready) chk("ready_timeout", 0, 1);
    instr_valid = 1'b1; reg_sel = s; oper = o; number = n;
    @(posedge clk); #1;                       // after edge N
    instr_valid = 1'b0; reg_sel = ~s; oper = ~o; number = ~n;
    chk("ready_low_n1", instr_ready, 0);
    chk("busy_n1", busy, 1);
    chk("done_n1", done, 0);
    @(posedge clk); #1;                       // after edge N+1
    chk("done_n2", done, 0);
    @(posedge clk); #1;                       // after edge N+2
    chk("done_n3", done, 0);
    chk("ready_low_n3", instr_ready, 0);
    @(posedge clk); #1;                       // after edge N+3
    chk("done_pulse", done, 1);
    chk("ready_back", instr_ready, 1);
    chk("busy_clear", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    // sel, op, num, exp r0, exp r1, exp led
    vecs[0]  = '{1'b0, 1'b0, 2'd3, 4'd3,  4'd0,  5'b00011};
    vecs[1]  = '{1'b1, 1'b0, 2'd3, 4'd3,  4'd3,  5'b00011};
    vecs[2]  = '{1'b1, 1'b0, 2'd3, 4'd3,  4'd6,  5'b00110};
    vecs[3]  = '{1'b1, 1'b0, 2'd3, 4'd3,  4'd9,  5'b01001};
    vecs[4]  = '{1'b1, 1'b0, 2'd3, 4'd3,  4'd12, 5'b01100};
    vecs[5]  = '{1'b1, 1'b0, 2'd3, 4'd3,  4'd15, 5'b01111};
    vecs[6]  = '{1'b1, 1'b0, 2'd1, 4'd3,  4'd0,  5'b10000};  // carry wrap
    vecs[7]  = '{1'b0, 1'b1, 2'd3, 4'd0,  4'd0,  5'b00000};
    vecs[8]  = '{1'b0, 1'b1, 2'd2, 4'd14, 4'd0,  5'b11110};  // borrow
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 4'd14, 4'd0,  5'b01110};
    vecs[10] = '{1'b1, 1'b1, 2'd1, 4'd14, 4'd15, 5'b11111};
    vecs[11] = '{1'b1, 1'b0, 2'd2, 4'd14, 4'd1,  5'b10001};
    vecs[12] = '{1'b0, 1'b0, 2'd1, 4'd15, 4'd1,  5'b01111};

    // Reset state
    do_reset();
    chk("rst_r0", r0, 0);
    chk("rst_r1", r1, 0);
    chk("rst_led", led, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", instr_ready, 1);
    $display("reset: r0=%0d r1=%0d led=%b ready=%0d", r0, r1, led, instr_ready);

    // Table-driven instructions
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].sel, vecs[i].op, vecs[i].num);
      chk($sformatf("v%0d_r0", i), r0, vecs[i].e_r0);
      chk($sformatf("v%0d_r1", i), r1, vecs[i].e_r1);
      chk($sformatf("v%0d_led", i), led, vecs[i].e_led);
      $display("vec %0d: sel=%0d op=%0d num=%0d -> r0=%0d r1=%0d led=%b",
               i, vecs[i].sel, vecs[i].op, vecs[i].num, r0, r1, led);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_clear", i), done, 0);
    end

    // Back-to-back with valid held high, inputs toggled during busy
    do_reset();
    @(negedge clk);
    instr_valid = 1'b1; reg_sel = 1'b0; oper = 1'b0; number = 2'd1;
    @(posedge clk); #1;                       // handshake 1 at edge N
    reg_sel = 1'b1; number = 2'd2;            // next instruction, valid stays high
    done_cnt = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          chk("b2b_first_at", k, 3);
          chk("b2b_first_r0", r0, 1);
          chk("b2b_first_r1", r1, 0);
        end else begin
          chk("b2b_second_at", k, 7);
        end
      end
      if (k == 4) instr_valid = 1'b0;
      if (k >= 4) begin
        number  = 2'($urandom_range(0, 3));
        oper    = 1'($urandom_range(0, 1));
        reg_sel = 1'($urandom_range(0, 1));
      end
    end
    chk("b2b_done_count", done_cnt, 2);
    chk("b2b_r0", r0, 1);
    chk("b2b_r1", r1, 2);
    $display("back-to-back: commits=%0d r0=%0d r1=%0d", done_cnt, r0, r1);

    // Reset during EXEC of add R0+3 with R0=5
    do_reset();
    issue(1'b0, 1'b0, 2'd3);
    issue(1'b0, 1'b0, 2'd2);
    chk("abort_pre_r0", r0, 5);
    @(negedge clk);
    instr_valid = 1'b1; reg_sel = 1'b0; oper = 1'b0; number = 2'd3;
    @(posedge clk); #1;                       // edge N: READ
    instr_valid = 1'b0;
    @(posedge clk); #1;                       // edge N+1: EXEC
    chk("abort_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    chk("abort_r0", r0, 0);
    chk("abort_r1", r1, 0);
    chk("abort_led", led, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    chk("abort_post_r0", r0, 0);
    chk("abort_post_led", led, 0);
    chk("abort_idle", instr_ready, 1);
    $display("reset mid-exec: r0=%0d r1=%0d led=%b dones=%0d", r0, r1, led, done_cnt);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
